swap_stage: RTL and testbench

SWAP_STAGE -- requirements
Module: swap_stage

---
 rtl/swap_stage_pkg.sv | 18 +
 rtl/swap_out_buf.sv | 53 +++++
 rtl/swap_stage.sv | 87 ++++++++
 tb/tb_swap_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/swap_stage_pkg.sv
// Shared encodings for the swap stage: command codes and FSM states.
package swap_stage_pkg;

   typedef enum logic [1:0] {
      CMD_LOAD_A = 2'd0,
      CMD_LOAD_B = 2'd1,
      CMD_SWAP   = 2'd2,
      CMD_READ   = 2'd3
   } cmd_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam int COUNT_W = 8;

endpackage : swap_stage_pkg

// File: rtl/swap_out_buf.sv
// Output holding register: captures an A/B pair on load and presents it with
// valid/ready semantics until the downstream takes it.
module swap_out_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;

   // Next-state: capture on load, drop valid on a handshake, otherwise hold.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      if (load) begin
         valid_d = 1'b1;
         a_d     = a_in;
         b_d     = b_in;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Holding registers, cleared asynchronously so a pending pair is dropped on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign out_valid = valid_q;
   assign out_a     = a_q;
   assign out_b     = b_q;

endmodule : swap_out_buf

// File: rtl/swap_stage.sv
// Two-register swap stage: load A or B, exchange them, or snapshot both into
// an output buffer that is held until the downstream accepts it.
module swap_stage
   import swap_stage_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_cmd,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_a,
   output logic [WIDTH-1:0]   out_b,
   output logic [COUNT_W-1:0] swap_count
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [COUNT_W-1:0]   swap_count_q, swap_count_d;
   cmd_e                 cmd;
   logic                 accept;
   logic                 read_accept;

   assign cmd         = cmd_e'(in_cmd);
   assign in_ready    = !rst && (state_q == ST_IDLE);
   assign accept      = in_valid && in_ready;
   assign read_accept = accept && (cmd == CMD_READ);

   // Command decode and FSM next-state; all values derive from pre-edge state.
   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      swap_count_d = swap_count_q;
      if (accept) begin
         case (cmd)
            CMD_LOAD_A: a_d = in_data;
            CMD_LOAD_B: b_d = in_data;
            CMD_SWAP: begin
               a_d          = b_q;
               b_d          = a_q;
               swap_count_d = swap_count_q + 8'd1;
            end
            CMD_READ:   state_d = ST_HOLD;
         endcase
      end
      if (state_q == ST_HOLD && out_valid && out_ready) begin
         state_d = ST_IDLE;
      end
   end

   // State and data registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         swap_count_q <= '0;
      end else begin
         // NOTE: non-blocking updates make SWAP read both old values before either is written.
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         swap_count_q <= swap_count_d;
      end
   end

   swap_out_buf #(.WIDTH(WIDTH)) u_out_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (read_accept),
      .a_in      (a_q),
      .b_in      (b_q),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_a     (out_a),
      .out_b     (out_b)
   );

   assign swap_count = swap_count_q;

endmodule : swap_stage

// File: tb/tb_swap_stage.sv
// Directed bench for swap_stage with hand-computed expectations.
module tb_swap_stage;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_cmd;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [7:0]       swap_count;

   int checks   = 0;
   int failures = 0;

   swap_stage #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_cmd     (in_cmd),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_a      (out_a),
      .out_b      (out_b),
      .swap_count (swap_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one command for one edge, then drop in_valid just after it.
   task automatic issue(input logic [1:0] c, input logic [WIDTH-1:0] d);
      in_valid = 1'b1;
      in_cmd   = c;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // READ with out_ready already high: pair appears after one edge, clears after the next.
   task automatic do_read(input string tag, input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
      out_ready = 1'b1;
      check({tag, "_pre_valid"}, 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_cmd   = 2'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_a"}, 32'(out_a), 32'(ea));
      check({tag, "_b"}, 32'(out_b), 32'(eb));
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_cleared"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      int acc;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_cmd    = 2'd0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_swap_count", 32'(swap_count), 32'd0);
      check("rst_out_a", 32'(out_a), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Load, swap, read: first command lands on the first edge after reset
      issue(2'd0, 8'h11);
      issue(2'd1, 8'h22);
      issue(2'd2, 8'h00);
      check("t1_swap_count", 32'(swap_count), 32'd1);
      do_read("t1_read", 8'h22, 8'h11);

      // out_ready high with no READ has no effect
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("idle_ready_no_valid", 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;
      do_read("idle_ready_read", 8'h22, 8'h11);

      // 256 back-to-back swaps wrap the counter and restore A/B
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      issue(2'd0, 8'h05);
      issue(2'd1, 8'h09);
      acc      = 0;
      in_valid = 1'b1;
      in_cmd   = 2'd2;
      for (int i = 0; i < 256; i++) begin
         if (in_ready) acc++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("wrap_accepts", 32'(acc), 32'd256);
      check("wrap_swap_count", 32'(swap_count), 32'd0);
      do_read("wrap_read", 8'h05, 8'h09);

      // Stalled READ: upstream LOAD_A held off while the pair waits
      issue(2'd3, 8'h00);
      check("stall_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      in_cmd   = 2'd0;
      in_data  = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_hold_valid", 32'(out_valid), 32'd1);
         check("stall_out_a", 32'(out_a), 32'h05);
         check("stall_out_b", 32'(out_b), 32'h09);
         check("stall_reg_a", 32'(dut.a_q), 32'h05);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hs_valid_clear", 32'(out_valid), 32'd0);
      check("hs_in_ready", 32'(in_ready), 32'd1);
      check("hs_no_accept_a", 32'(dut.a_q), 32'h05);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hs_next_load_a", 32'(dut.a_q), 32'hAA);
      do_read("hs_read", 8'hAA, 8'h09);

      // SWAP then READ in consecutive cycles captures post-swap values
      issue(2'd0, 8'h03);
      issue(2'd1, 8'h07);
      in_valid = 1'b1;
      in_cmd   = 2'd2;
      @(posedge clk);
      #1;
      in_cmd = 2'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("sr_valid", 32'(out_valid), 32'd1);
      check("sr_out_a", 32'(out_a), 32'h07);
      check("sr_out_b", 32'(out_b), 32'h03);
      check("sr_swap_count", 32'(swap_count), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("sr_cleared", 32'(out_valid), 32'd0);

      // Reset pulsed mid-HOLD acts without a clock edge
      issue(2'd2, 8'h00);
      check("mid_swap_count", 32'(swap_count), 32'd2);
      issue(2'd3, 8'h00);
      check("mid_hold_valid", 32'(out_valid), 32'd1);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_a", 32'(out_a), 32'd0);
      check("mid_rst_out_b", 32'(out_b), 32'd0);
      check("mid_rst_count", 32'(swap_count), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_reg_a", 32'(dut.a_q), 32'd0);
      check("mid_rst_reg_b", 32'(dut.b_q), 32'd0);
      #2 rst = 1'b0;
      do_read("mid_rst_read", 8'h00, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_swap_stage
